// File: rtl/multi_cycle_controller_if.sv
// Control bundle between the multi-cycle RV32I controller (master) and the datapath (slave).
// MULTI_CYCLE_CONTROLLER_MEM_READY_EN adds the i_memReady handshake from memory.
interface multi_cycle_controller_if #(
    parameter int INSTRET_W = 32
);
    logic [6:0]           i_operand;
    logic [2:0]           i_funct3;
    logic                 i_funct7b5;
    logic                 i_zero;
`ifdef MULTI_CYCLE_CONTROLLER_MEM_READY_EN
    logic                 i_memReady;
`endif
    logic                 o_pcWrite;
    logic                 o_adrSrc;
    logic                 o_irWrite;
    logic                 o_memWrite;
    logic                 o_regWrite;
    logic [1:0]           o_resultSrc;
    logic [1:0]           o_aluSrcA;
    logic [1:0]           o_aluSrcB;
    logic [1:0]           o_immSrc;
    logic [2:0]           o_aluControl;
    logic                 o_illegal;
    logic [INSTRET_W-1:0] o_instret;

    modport master (
`ifdef MULTI_CYCLE_CONTROLLER_MEM_READY_EN
        input  i_memReady,
`endif
        input  i_operand, i_funct3, i_funct7b5, i_zero,
        output o_pcWrite, o_adrSrc, o_irWrite, o_memWrite, o_regWrite,
        output o_resultSrc, o_aluSrcA, o_aluSrcB, o_immSrc, o_aluControl,
        output o_illegal, o_instret
    );

    modport slave (
`ifdef MULTI_CYCLE_CONTROLLER_MEM_READY_EN
        output i_memReady,
`endif
        output i_operand, i_funct3, i_funct7b5, i_zero,
        input  o_pcWrite, o_adrSrc, o_irWrite, o_memWrite, o_regWrite,
        input  o_resultSrc, o_aluSrcA, o_aluSrcB, o_immSrc, o_aluControl,
        input  o_illegal, o_instret
    );
endinterface

// File: rtl/multi_cycle_controller.sv
// Main FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/writeback,
// counts retired instructions. MULTI_CYCLE_CONTROLLER_MEM_READY_EN enables memory wait states.
module multi_cycle_controller #(
    parameter int INSTRET_W = 32
) (
    input  logic                            i_clk,
    input  logic                            i_arst,
    multi_cycle_controller_if.master        io_ctrl
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'h03;
    localparam logic [6:0] OP_SW  = 7'h23;
    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_BEQ = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6F;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Only R-type may turn funct3=000 into a subtract; addi ignores instr[30].
    function automatic logic [2:0] alu_decode(input logic [2:0] funct3,
                                              input logic       funct7b5,
                                              input logic       is_rtype);
        logic [2:0] op;
        case (funct3)
            3'b000:  op = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    state_t               r_state;
    state_t               w_next_state;
    logic [INSTRET_W-1:0] r_instret;
    logic                 w_mem_ready;
    logic                 w_retire;

    logic       w_pc_write;
    logic       w_adr_src;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_imm_src;
    logic [2:0] w_alu_control;
    logic       w_illegal;

`ifdef MULTI_CYCLE_CONTROLLER_MEM_READY_EN
    assign w_mem_ready = io_ctrl.i_memReady;
`else
    assign w_mem_ready = 1'b1;
`endif

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // An instruction retires when it returns to FETCH; DECODE->FETCH is the illegal path.
    assign w_retire = (w_next_state == S_FETCH) && (r_state != S_FETCH) && (r_state != S_DECODE);

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
        end else begin
            r_instret <= r_instret;
        end
    end

    // Next-state and control decode.
    always_comb begin
        w_next_state  = r_state;
        w_pc_write    = 1'b0;
        w_adr_src     = 1'b0;
        w_ir_write    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_result_src  = 2'b00;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_imm_src     = 2'b00;
        w_alu_control = ALU_ADD;
        w_illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_adr_src     = 1'b0;
                w_ir_write    = w_mem_ready;
                w_alu_src_a   = 2'b00;
                w_alu_src_b   = 2'b10;
                w_alu_control = ALU_ADD;
                w_result_src  = 2'b10;
                w_pc_write    = w_mem_ready;
                w_next_state  = w_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_alu_src_a   = 2'b01;
                w_alu_src_b   = 2'b01;
                w_imm_src     = 2'b10;
                w_alu_control = ALU_ADD;
                case (io_ctrl.i_operand)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECR;
                    OP_I:         w_next_state = S_EXECI;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_JAL:       w_next_state = S_JAL;
                    default: begin
                        w_next_state = S_FETCH;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b01;
                w_alu_control = ALU_ADD;
                w_imm_src     = (io_ctrl.i_operand == OP_SW) ? 2'b01 : 2'b00;
                w_next_state  = (io_ctrl.i_operand == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adr_src    = 1'b1;
                w_next_state = w_mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src    = 1'b1;
                w_mem_write  = w_mem_ready;
                w_next_state = w_mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b00;
                w_alu_control = alu_decode(io_ctrl.i_funct3, io_ctrl.i_funct7b5, 1'b1);
                w_next_state  = S_ALUWB;
            end
            S_EXECI: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b01;
                w_imm_src     = 2'b00;
                w_alu_control = alu_decode(io_ctrl.i_funct3, io_ctrl.i_funct7b5, 1'b0);
                w_next_state  = S_ALUWB;
            end
            S_ALUWB: begin
                w_result_src = 2'b00;
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BEQ: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b00;
                w_alu_control = ALU_SUB;
                w_result_src  = 2'b00;
                w_pc_write    = io_ctrl.i_zero;
                w_next_state  = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms oldPC+4 for ALUWB.
                w_alu_src_a   = 2'b01;
                w_alu_src_b   = 2'b10;
                w_alu_control = ALU_ADD;
                w_result_src  = 2'b00;
                w_pc_write    = 1'b1;
                w_next_state  = S_ALUWB;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Strobes are masked while reset is held, since reset parks the FSM in FETCH.
    assign io_ctrl.o_pcWrite    = w_pc_write  & ~i_arst;
    assign io_ctrl.o_irWrite    = w_ir_write  & ~i_arst;
    assign io_ctrl.o_memWrite   = w_mem_write & ~i_arst;
    assign io_ctrl.o_regWrite   = w_reg_write & ~i_arst;
    assign io_ctrl.o_adrSrc     = w_adr_src;
    assign io_ctrl.o_resultSrc  = w_result_src;
    assign io_ctrl.o_aluSrcA    = w_alu_src_a;
    assign io_ctrl.o_aluSrcB    = w_alu_src_b;
    assign io_ctrl.o_immSrc     = w_imm_src;
    assign io_ctrl.o_aluControl = w_alu_control;
    assign io_ctrl.o_illegal    = w_illegal & ~i_arst;
    assign io_ctrl.o_instret    = r_instret;
endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: per-instruction vector table plus reset/wait-state sequences.
module tb_multi_cycle_controller;
    logic i_clk = 1'b0;
    logic i_arst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 i_clk = ~i_clk;

    multi_cycle_controller_if #(.INSTRET_W(32)) bus ();
    multi_cycle_controller #(.INSTRET_W(32)) dut (
        .i_clk   (i_clk),
        .i_arst  (i_arst),
        .io_ctrl (bus)
    );

    // Masks: bit k set means the signal is expected high in cycle k+1 (cycle 1 = FETCH).
    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          cycles;
        logic [15:0] pcw;
        logic [15:0] regw;
        logic [15:0] memw;
        logic [15:0] ill;
        logic [15:0] adr;
        logic [15:0] res01;
        logic [2:0]  alu3;
        logic [1:0]  srca3;
        logic [1:0]  srcb3;
        logic [1:0]  imm3;
        int          inc;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [15:0] pcw, regw, memw, ill, adr, res01;
        logic [2:0]  alu3;
        logic [5:0]  sel3;
        logic [5:0]  dec;
        logic [31:0] start;
        int          cyc;
        bit          done;
        pcw = '0; regw = '0; memw = '0; ill = '0; adr = '0; res01 = '0;
        alu3 = 3'b111; sel3 = 6'h3F; dec = 6'h00;
        bus.i_operand  = v.instr[6:0];
        bus.i_funct3   = v.instr[14:12];
        bus.i_funct7b5 = v.instr[30];
        bus.i_zero     = v.zero;
        start = bus.o_instret;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 16) begin
            #1;
            if (cyc > 0 && bus.o_irWrite) begin
                done = 1'b1;
            end else begin
                pcw[cyc]   = bus.o_pcWrite;
                regw[cyc]  = bus.o_regWrite;
                memw[cyc]  = bus.o_memWrite;
                ill[cyc]   = bus.o_illegal;
                adr[cyc]   = bus.o_adrSrc;
                res01[cyc] = (bus.o_resultSrc == 2'b01);
                if (cyc == 1) dec = {bus.o_aluSrcA, bus.o_aluSrcB, bus.o_immSrc};
                if (cyc == 2) begin
                    alu3 = bus.o_aluControl;
                    sel3 = {bus.o_aluSrcA, bus.o_aluSrcB, bus.o_immSrc};
                end
                @(negedge i_clk);
                cyc++;
            end
        end
        check($sformatf("v%0d.finished", idx), {31'd0, done}, 32'd1);
        check($sformatf("v%0d.cycles", idx), cyc, v.cycles);
        check($sformatf("v%0d.pcWrite", idx), {16'd0, pcw}, {16'd0, v.pcw});
        check($sformatf("v%0d.regWrite", idx), {16'd0, regw}, {16'd0, v.regw});
        check($sformatf("v%0d.memWrite", idx), {16'd0, memw}, {16'd0, v.memw});
        check($sformatf("v%0d.illegal", idx), {16'd0, ill}, {16'd0, v.ill});
        check($sformatf("v%0d.adrSrc", idx), {16'd0, adr}, {16'd0, v.adr});
        check($sformatf("v%0d.resultSrc01", idx), {16'd0, res01}, {16'd0, v.res01});
        check($sformatf("v%0d.decodeSel", idx), {26'd0, dec}, {26'd0, 6'b01_01_10});
        if (v.cycles >= 3) begin
            check($sformatf("v%0d.aluControl3", idx), {29'd0, alu3}, {29'd0, v.alu3});
            check($sformatf("v%0d.sel3", idx), {26'd0, sel3}, {26'd0, v.srca3, v.srcb3, v.imm3});
        end
        check($sformatf("v%0d.instretDelta", idx), bus.o_instret - start, v.inc);
    endtask

    initial begin
        //            instr         z     cyc pcw      regw     memw     ill      adr      res01    alu     sa     sb     imm    inc
        vecs[0]  = '{32'h00002083, 1'b0, 5, 16'h0001, 16'h0010, 16'h0000, 16'h0000, 16'h0008, 16'h0010, 3'b000, 2'b10, 2'b01, 2'b00, 1};
        vecs[1]  = '{32'h00102023, 1'b0, 4, 16'h0001, 16'h0000, 16'h0008, 16'h0000, 16'h0008, 16'h0000, 3'b000, 2'b10, 2'b01, 2'b01, 1};
        vecs[2]  = '{32'h40208033, 1'b0, 4, 16'h0001, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b001, 2'b10, 2'b00, 2'b00, 1};
        vecs[3]  = '{32'h00208033, 1'b0, 4, 16'h0001, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 2'b10, 2'b00, 2'b00, 1};
        vecs[4]  = '{32'h0020F033, 1'b0, 4, 16'h0001, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b010, 2'b10, 2'b00, 2'b00, 1};
        vecs[5]  = '{32'h0020E033, 1'b0, 4, 16'h0001, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b011, 2'b10, 2'b00, 2'b00, 1};
        vecs[6]  = '{32'h0020A033, 1'b0, 4, 16'h0001, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b101, 2'b10, 2'b00, 2'b00, 1};
        vecs[7]  = '{32'h00209033, 1'b0, 4, 16'h0001, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 2'b10, 2'b00, 2'b00, 1};
        vecs[8]  = '{32'h40008093, 1'b0, 4, 16'h0001, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 2'b10, 2'b01, 2'b00, 1};
        vecs[9]  = '{32'h0000A093, 1'b0, 4, 16'h0001, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b101, 2'b10, 2'b01, 2'b00, 1};
        vecs[10] = '{32'h0000E093, 1'b0, 4, 16'h0001, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b011, 2'b10, 2'b01, 2'b00, 1};
        vecs[11] = '{32'h0000F093, 1'b0, 4, 16'h0001, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b010, 2'b10, 2'b01, 2'b00, 1};
        vecs[12] = '{32'h00208063, 1'b1, 3, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b001, 2'b10, 2'b00, 2'b00, 1};
        vecs[13] = '{32'h00208063, 1'b0, 3, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b001, 2'b10, 2'b00, 2'b00, 1};
        vecs[14] = '{32'h008000EF, 1'b0, 4, 16'h0005, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 2'b01, 2'b10, 2'b00, 1};
        vecs[15] = '{32'h0000007F, 1'b0, 2, 16'h0001, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 3'b000, 2'b00, 2'b00, 2'b00, 0};

        i_arst         = 1'b1;
        bus.i_operand  = 7'h00;
        bus.i_funct3   = 3'b000;
        bus.i_funct7b5 = 1'b0;
        bus.i_zero     = 1'b0;
`ifdef MULTI_CYCLE_CONTROLLER_MEM_READY_EN
        bus.i_memReady = 1'b1;
`endif

        // Reset held three cycles: no strobes, counter cleared.
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        #1;
        check("rst.pcWrite",  {31'd0, bus.o_pcWrite},  32'd0);
        check("rst.irWrite",  {31'd0, bus.o_irWrite},  32'd0);
        check("rst.memWrite", {31'd0, bus.o_memWrite}, 32'd0);
        check("rst.regWrite", {31'd0, bus.o_regWrite}, 32'd0);
        check("rst.illegal",  {31'd0, bus.o_illegal},  32'd0);
        check("rst.instret",  bus.o_instret,           32'd0);
        i_arst = 1'b0;
        #1;
        check("rel.irWrite",  {31'd0, bus.o_irWrite},  32'd1);
        check("rel.pcWrite",  {31'd0, bus.o_pcWrite},  32'd1);
        check("rel.memWrite", {31'd0, bus.o_memWrite}, 32'd0);
        check("rel.instret",  bus.o_instret,           32'd0);
        check("rel.aluSrcB",  {30'd0, bus.o_aluSrcB},  32'd2);
        check("rel.resultSrc", {30'd0, bus.o_resultSrc}, 32'd2);

        for (int i = 0; i < 16; i++) begin
            run_vec(i, vecs[i]);
        end
        check("table.instretTotal", bus.o_instret, 32'd15);

        // Asynchronous reset while the store strobe is high.
        bus.i_operand  = 7'h23;
        bus.i_funct3   = 3'b010;
        bus.i_funct7b5 = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        check("swrst.memWriteBefore", {31'd0, bus.o_memWrite}, 32'd1);
        i_arst = 1'b1;
        #1;
        check("swrst.memWrite", {31'd0, bus.o_memWrite}, 32'd0);
        check("swrst.adrSrc",   {31'd0, bus.o_adrSrc},   32'd0);
        check("swrst.pcWrite",  {31'd0, bus.o_pcWrite},  32'd0);
        check("swrst.instret",  bus.o_instret,           32'd0);
        @(negedge i_clk);
        i_arst = 1'b0;
        #1;
        check("swrst.fetchIrWrite", {31'd0, bus.o_irWrite}, 32'd1);
        check("swrst.fetchAluSrcB", {30'd0, bus.o_aluSrcB}, 32'd2);

`ifdef MULTI_CYCLE_CONTROLLER_MEM_READY_EN
        // FETCH wait states: held with strobes off, then one pcWrite on ready.
        bus.i_operand  = 7'h33;
        bus.i_memReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rdy.wait%0d.pcWrite", k), {31'd0, bus.o_pcWrite}, 32'd0);
            check($sformatf("rdy.wait%0d.irWrite", k), {31'd0, bus.o_irWrite}, 32'd0);
            check($sformatf("rdy.wait%0d.aluSrcB", k), {30'd0, bus.o_aluSrcB}, 32'd2);
            @(negedge i_clk);
            #1;
        end
        bus.i_memReady = 1'b1;
        #1;
        check("rdy.pcWrite", {31'd0, bus.o_pcWrite}, 32'd1);
        check("rdy.irWrite", {31'd0, bus.o_irWrite}, 32'd1);
        @(negedge i_clk);
        #1;
        check("rdy.decodePcWrite", {31'd0, bus.o_pcWrite}, 32'd0);
        check("rdy.decodeAluSrcA", {30'd0, bus.o_aluSrcA}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
